// File: rtl/usb_vip_pkg.sv
// Shared definitions for the USB slave-FIFO VIP: pattern modes, default
// endpoint addresses and LFSR tap masks.
package usb_vip_pkg;

  typedef enum int unsigned {
    PAT_INC  = 0,
    PAT_LFSR = 1
  } pat_mode_e;

  localparam logic [1:0] DEF_DL_ADDR = 2'd0;
  localparam logic [1:0] DEF_UL_ADDR = 2'd2;

  // Fibonacci feedback taps (bit i set = stage i+1 tapped), maximal length.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      8:       return 32'h0000_00B8;  // x^8 + x^6 + x^5 + x^4 + 1
      32:      return 32'h8020_0003;  // x^32 + x^22 + x^2 + x + 1
      default: return 32'h0000_B400;  // x^16 + x^14 + x^13 + x^11 + 1
    endcase
  endfunction

endpackage

// File: rtl/usb_vip_pattern_gen.sv
// Download data source: incrementing counter or Fibonacci LFSR, stepped once
// per accepted read and reloaded to the seed on reset.
module usb_vip_pattern_gen
  import usb_vip_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int PAT_MODE = 0,
  parameter int PAT_SEED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  output logic [DATA_W-1:0] data
);

  localparam logic              IS_LFSR  = (PAT_MODE == int'(PAT_LFSR));
  localparam logic [DATA_W-1:0] TAPS     = DATA_W'(lfsr_taps(DATA_W));
  localparam logic [DATA_W-1:0] RAW_SEED = DATA_W'(PAT_SEED);
  // An all-zero LFSR would lock up, so a zero seed becomes 1 in that mode.
  localparam logic [DATA_W-1:0] SEED =
    (IS_LFSR && (RAW_SEED == '0)) ? DATA_W'(1) : RAW_SEED;

  logic [DATA_W-1:0] next_data;

  // Next pattern word for the selected mode.
  always_comb begin
    next_data = data + DATA_W'(1);
    if (IS_LFSR) next_data = {data[DATA_W-2:0], ^(data & TAPS)};
  end

  // Pattern register: seed on reset, step on each accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       data <= SEED;
    else if (advance) data <= next_data;
  end

endmodule

// File: rtl/usb_slfifo_vip.sv
// Slave-FIFO endpoint model: a download endpoint streaming a generated
// pattern and an upload endpoint capturing bus writes into a local buffer.
module usb_slfifo_vip
  import usb_vip_pkg::*;
#(
  parameter int         DATA_W      = 16,
  parameter int         DL_LEN      = 256,
  parameter int         UL_DEPTH    = 512,
  parameter logic [1:0] DL_ADDR     = DEF_DL_ADDR,
  parameter logic [1:0] UL_ADDR     = DEF_UL_ADDR,
  parameter int         PAT_MODE    = 0,
  parameter int         PAT_SEED    = 1,
  parameter int         STARTUP_CYC = 10
) (
  input  logic              usb_clk,
  input  logic              rst_n,
  input  logic [1:0]        usb_fifoaddr,
  input  logic              usb_slcs,
  input  logic              usb_sloe,
  input  logic              usb_slrd,
  input  logic              usb_slwr,
  input  logic              usb_pktend,
  inout  logic [DATA_W-1:0] usb_fd,
  output logic              usb_flaga,
  output logic              usb_flagb,
  output logic              usb_flagc,
  output logic              usb_download_finished,
  output logic [15:0]       ul_word_cnt,
  output logic [15:0]       ul_pkt_cnt,
  output logic              ul_err,
  input  logic              ul_rd_en,
  output logic [DATA_W-1:0] ul_rd_data
);

  localparam int          AW     = $clog2(UL_DEPTH);
  localparam logic [15:0] SU_MAX = 16'(STARTUP_CYC);
  localparam logic [15:0] DL_MAX = 16'(DL_LEN);

  logic [15:0]       su_cnt;
  logic              su_done;
  logic [15:0]       remaining;
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] mem [UL_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              full, empty;
  logic              sel_dl, sel_ul, rd_req, rd_ok, wr_req, push, pop, pkt;
  logic              both_strobe, bus_fight, err_set;

  assign su_done = (su_cnt >= SU_MAX);
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign sel_dl      = ~usb_slcs & (usb_fifoaddr == DL_ADDR);
  assign sel_ul      = ~usb_slcs & (usb_fifoaddr == UL_ADDR);
  assign rd_req      = sel_dl & ~usb_slrd;
  assign rd_ok       = rd_req & (remaining != '0);
  assign both_strobe = ~usb_slcs & ~usb_slrd & ~usb_slwr;
  assign bus_fight   = ~usb_slcs & ~usb_sloe & ~usb_slwr;
  assign wr_req      = sel_ul & ~usb_slwr;
  // A write is refused both on a full buffer and on any strobe conflict.
  assign push        = wr_req & ~full & ~both_strobe & ~bus_fight;
  assign pop         = ul_rd_en & ~empty;
  assign pkt         = sel_ul & ~usb_pktend;
  assign err_set     = (rd_req & (remaining == '0)) | (wr_req & full) |
                       both_strobe | bus_fight;

  assign usb_fd = (sel_dl & ~usb_sloe) ? pat : 'z;

  assign usb_flaga             = su_done & (remaining != '0);
  assign usb_flagb             = su_done & ~full;
  assign usb_flagc             = ~su_done | empty;
  assign usb_download_finished = (remaining == '0);
  assign ul_rd_data            = mem[rd_ptr[AW-1:0]];

  usb_vip_pattern_gen #(
    .DATA_W  (DATA_W),
    .PAT_MODE(PAT_MODE),
    .PAT_SEED(PAT_SEED)
  ) u_pat (
    .clk    (usb_clk),
    .rst_n  (rst_n),
    .advance(rd_ok),
    .data   (pat)
  );

  // Start-up delay counter, saturating once flags are allowed to go live.
  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n)        su_cnt <= '0;
    else if (!su_done) su_cnt <= su_cnt + 16'd1;
  end

  // Download bookkeeping: words left to supply.
  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n)     remaining <= DL_MAX;
    else if (rd_ok) remaining <= remaining - 16'd1;
  end

  // Upload buffer storage; contents need no reset since pointers gate reads.
  always_ff @(posedge usb_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= usb_fd;
  end

  // Upload pointers, counters and sticky error flag.
  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ul_word_cnt <= '0;
      ul_pkt_cnt  <= '0;
      ul_err      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && (ul_word_cnt != 16'hFFFF)) ul_word_cnt <= ul_word_cnt + 16'd1;
      if (pkt)     ul_pkt_cnt <= ul_pkt_cnt + 16'd1;
      if (err_set) ul_err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_slfifo_vip.sv
// Bench for usb_slfifo_vip: three instances (16-bit incrementing with a
// 4-deep upload buffer, 8-bit wrap, 16-bit LFSR) sharing one set of strobes.
module tb_usb_slfifo_vip;

  localparam int STARTUP = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        slcs = 1'b1, sloe = 1'b1, slrd = 1'b1, slwr = 1'b1, pktend = 1'b1;
  logic        rd_en = 1'b0;
  logic        tb_drv = 1'b0;
  logic [31:0] tb_data = '0;

  wire  [15:0] fd_a, fd_c;
  wire  [7:0]  fd_b;
  logic        a_flaga, a_flagb, a_flagc, a_fin, a_err;
  logic [15:0] a_words, a_pkts, a_rd;
  logic        b_flaga, b_flagb, b_flagc, b_fin, b_err;
  logic [15:0] b_words, b_pkts;
  logic [7:0]  b_rd;
  logic        c_flaga, c_flagb, c_flagc, c_fin, c_err;
  logic [15:0] c_words, c_pkts, c_rd;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q[$];
  logic [31:0] exp_v;

  assign fd_a = tb_drv ? tb_data[15:0] : 'z;
  assign fd_b = tb_drv ? tb_data[7:0]  : 'z;
  assign fd_c = tb_drv ? tb_data[15:0] : 'z;

  always #5 clk = ~clk;

  usb_slfifo_vip #(.DATA_W(16), .DL_LEN(256), .UL_DEPTH(4), .PAT_MODE(0),
                   .PAT_SEED(1), .STARTUP_CYC(STARTUP)) dut_a (
    .usb_clk(clk), .rst_n(rst_n), .usb_fifoaddr(addr), .usb_slcs(slcs),
    .usb_sloe(sloe), .usb_slrd(slrd), .usb_slwr(slwr), .usb_pktend(pktend),
    .usb_fd(fd_a), .usb_flaga(a_flaga), .usb_flagb(a_flagb), .usb_flagc(a_flagc),
    .usb_download_finished(a_fin), .ul_word_cnt(a_words), .ul_pkt_cnt(a_pkts),
    .ul_err(a_err), .ul_rd_en(rd_en), .ul_rd_data(a_rd));

  usb_slfifo_vip #(.DATA_W(8), .DL_LEN(256), .UL_DEPTH(4), .PAT_MODE(0),
                   .PAT_SEED(8'hFE), .STARTUP_CYC(STARTUP)) dut_b (
    .usb_clk(clk), .rst_n(rst_n), .usb_fifoaddr(addr), .usb_slcs(slcs),
    .usb_sloe(sloe), .usb_slrd(slrd), .usb_slwr(slwr), .usb_pktend(pktend),
    .usb_fd(fd_b), .usb_flaga(b_flaga), .usb_flagb(b_flagb), .usb_flagc(b_flagc),
    .usb_download_finished(b_fin), .ul_word_cnt(b_words), .ul_pkt_cnt(b_pkts),
    .ul_err(b_err), .ul_rd_en(rd_en), .ul_rd_data(b_rd));

  usb_slfifo_vip #(.DATA_W(16), .DL_LEN(256), .UL_DEPTH(4), .PAT_MODE(1),
                   .PAT_SEED(16'hACE1), .STARTUP_CYC(STARTUP)) dut_c (
    .usb_clk(clk), .rst_n(rst_n), .usb_fifoaddr(addr), .usb_slcs(slcs),
    .usb_sloe(sloe), .usb_slrd(slrd), .usb_slwr(slwr), .usb_pktend(pktend),
    .usb_fd(fd_c), .usb_flaga(c_flaga), .usb_flagb(c_flagb), .usb_flagc(c_flagc),
    .usb_download_finished(c_fin), .ul_word_cnt(c_words), .ul_pkt_cnt(c_pkts),
    .ul_err(c_err), .ul_rd_en(rd_en), .ul_rd_data(c_rd));

  task automatic idle();
    slcs = 1'b1; sloe = 1'b1; slrd = 1'b1; slwr = 1'b1; pktend = 1'b1;
    rd_en = 1'b0; tb_drv = 1'b0; addr = 2'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (STARTUP + 2) @(negedge clk);
    q.delete();
  endtask

  task automatic drive_read();
    addr = 2'd0; slcs = 1'b0; sloe = 1'b0; slrd = 1'b0; slwr = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic drive_write(input logic [31:0] d);
    addr = 2'd2; slcs = 1'b0; sloe = 1'b1; slrd = 1'b1; slwr = 1'b0;
    tb_drv = 1'b1; tb_data = d;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_flaga !== 1'b0) begin n_fail++; $display("FAIL rst_flaga got=%b exp=0", a_flaga); end
    n_checks++; if (a_flagb !== 1'b0) begin n_fail++; $display("FAIL rst_flagb got=%b exp=0", a_flagb); end
    n_checks++; if (a_flagc !== 1'b1) begin n_fail++; $display("FAIL rst_flagc got=%b exp=1", a_flagc); end
    n_checks++; if (a_fin !== 1'b0) begin n_fail++; $display("FAIL rst_finished got=%b exp=0", a_fin); end
    n_checks++; if ({a_words, a_pkts, a_err} !== 33'd0) begin n_fail++; $display("FAIL rst_counters got=%h/%h/%b exp=0", a_words, a_pkts, a_err); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (STARTUP - 1) @(negedge clk);
    #1;
    n_checks++; if (a_flaga !== 1'b0) begin n_fail++; $display("FAIL startup_last_cycle flaga got=%b exp=0", a_flaga); end
    @(negedge clk);
    #1;
    n_checks++; if (a_flaga !== 1'b1) begin n_fail++; $display("FAIL startup_done flaga got=%b exp=1", a_flaga); end
    n_checks++; if (a_flagb !== 1'b1) begin n_fail++; $display("FAIL startup_done flagb got=%b exp=1", a_flagb); end
    n_checks++; if (a_flagc !== 1'b1) begin n_fail++; $display("FAIL startup_done flagc got=%b exp=1", a_flagc); end
  endtask

  task automatic test_download();
    do_reset();
    for (int i = 1; i <= 256; i++) q.push_back(32'(i));
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      drive_read();
      #1;
      exp_v = q.pop_front();
      n_checks++; if (fd_a !== exp_v[15:0]) begin n_fail++; $display("FAIL dl_word[%0d] got=%h exp=%h", i, fd_a, exp_v[15:0]); end
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (a_fin !== 1'b1) begin n_fail++; $display("FAIL dl_finished got=%b exp=1", a_fin); end
    n_checks++; if (a_flaga !== 1'b0) begin n_fail++; $display("FAIL dl_flaga_empty got=%b exp=0", a_flaga); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL dl_err_early got=%b exp=0", a_err); end
    drive_read();
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL dl_overread_err got=%b exp=1", a_err); end
    n_checks++; if (a_fin !== 1'b1) begin n_fail++; $display("FAIL dl_overread_fin got=%b exp=1", a_fin); end
  endtask

  task automatic test_wrap8();
    do_reset();
    q.push_back(32'hFE); q.push_back(32'hFF); q.push_back(32'h00); q.push_back(32'h01);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_read();
      #1;
      exp_v = q.pop_front();
      n_checks++; if (fd_b !== exp_v[7:0]) begin n_fail++; $display("FAIL wrap8_word[%0d] got=%h exp=%h", i, fd_b, exp_v[7:0]); end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_lfsr();
    logic [15:0] m;
    do_reset();
    m = 16'hACE1;
    for (int i = 0; i < 32; i++) begin
      q.push_back({16'h0, m});
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive_read();
      #1;
      exp_v = q.pop_front();
      n_checks++; if (fd_c !== exp_v[15:0]) begin n_fail++; $display("FAIL lfsr_word[%0d] got=%h exp=%h", i, fd_c, exp_v[15:0]); end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_upload_full();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive_write(32'hA1 + 32'(k));
      if (k < 4) q.push_back(32'hA1 + 32'(k));
      @(posedge clk);
      #1;
      if (k == 2) begin
        n_checks++; if (a_flagb !== 1'b1) begin n_fail++; $display("FAIL ul_flagb_3rd got=%b exp=1", a_flagb); end
      end
      if (k == 3) begin
        n_checks++; if (a_flagb !== 1'b0) begin n_fail++; $display("FAIL ul_flagb_full got=%b exp=0", a_flagb); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL ul_err_before_drop got=%b exp=0", a_err); end
      end
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL ul_drop_err got=%b exp=1", a_err); end
    n_checks++; if (a_words !== 16'd4) begin n_fail++; $display("FAIL ul_drop_words got=%0d exp=4", a_words); end
    n_checks++; if (a_flagc !== 1'b0) begin n_fail++; $display("FAIL ul_flagc_busy got=%b exp=0", a_flagc); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd_en = 1'b1;
      #1;
      exp_v = q.pop_front();
      n_checks++; if (a_rd !== exp_v[15:0]) begin n_fail++; $display("FAIL ul_pop[%0d] got=%h exp=%h", i, a_rd, exp_v[15:0]); end
    end
    @(negedge clk);
    rd_en = 1'b0;
    #1;
    n_checks++; if (a_flagc !== 1'b1) begin n_fail++; $display("FAIL ul_drained_flagc got=%b exp=1", a_flagc); end
    n_checks++; if (a_flagb !== 1'b1) begin n_fail++; $display("FAIL ul_drained_flagb got=%b exp=1", a_flagb); end
  endtask

  task automatic test_pktend();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_write(32'hB1 + 32'(k));
      pktend = (k == 2) ? 1'b0 : 1'b1;
      q.push_back(32'hB1 + 32'(k));
      @(posedge clk);
      #1;
      if (k == 1) begin
        n_checks++; if (a_pkts !== 16'd0) begin n_fail++; $display("FAIL pkt_early got=%0d exp=0", a_pkts); end
      end
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (a_pkts !== 16'd1) begin n_fail++; $display("FAIL pkt_cnt got=%0d exp=1", a_pkts); end
    n_checks++; if (a_words !== 16'd3) begin n_fail++; $display("FAIL pkt_words got=%0d exp=3", a_words); end
    // Simultaneous push and pop: occupancy must stay at three.
    drive_write(32'hB4);
    rd_en = 1'b1;
    q.push_back(32'hB4);
    #1;
    exp_v = q.pop_front();
    n_checks++; if (a_rd !== exp_v[15:0]) begin n_fail++; $display("FAIL pushpop_head got=%h exp=%h", a_rd, exp_v[15:0]); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      rd_en = 1'b1;
      #1;
      exp_v = q.pop_front();
      n_checks++; if (a_rd !== exp_v[15:0]) begin n_fail++; $display("FAIL pushpop_pop[%0d] got=%h exp=%h", i, a_rd, exp_v[15:0]); end
    end
    @(negedge clk);
    rd_en = 1'b0;
    #1;
    n_checks++; if (a_flagc !== 1'b1) begin n_fail++; $display("FAIL pushpop_empty got=%b exp=1", a_flagc); end
    n_checks++; if (a_words !== 16'd4) begin n_fail++; $display("FAIL pushpop_words got=%0d exp=4", a_words); end
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL pushpop_err got=%b exp=0", a_err); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      drive_read();
      #1;
      n_checks++; if (fd_a !== 16'(i)) begin n_fail++; $display("FAIL mid_word[%0d] got=%h exp=%h", i, fd_a, 16'(i)); end
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (a_flaga !== 1'b1) begin n_fail++; $display("FAIL mid_flaga_pre got=%b exp=1", a_flaga); end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({a_flaga, a_flagb, a_flagc, a_fin} !== 4'b0010) begin n_fail++; $display("FAIL mid_async_flags got=%b exp=0010", {a_flaga, a_flagb, a_flagc, a_fin}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (STARTUP + 2) @(negedge clk);
    drive_read();
    #1;
    n_checks++; if (fd_a !== 16'd1) begin n_fail++; $display("FAIL mid_restart_a got=%h exp=0001", fd_a); end
    n_checks++; if (fd_c !== 16'hACE1) begin n_fail++; $display("FAIL mid_restart_c got=%h exp=ace1", fd_c); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_contention();
    do_reset();
    drive_write(32'h55);
    slrd = 1'b0;
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL rdwr_err got=%b exp=1", a_err); end
    n_checks++; if (a_words !== 16'd0) begin n_fail++; $display("FAIL rdwr_words got=%0d exp=0", a_words); end
    do_reset();
    #1;
    n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared got=%b exp=0", a_err); end
    drive_write(32'h66);
    sloe = 1'b0;
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL oe_wr_err got=%b exp=1", a_err); end
    n_checks++; if (a_words !== 16'd0) begin n_fail++; $display("FAIL oe_wr_words got=%0d exp=0", a_words); end
    n_checks++; if (a_flagc !== 1'b1) begin n_fail++; $display("FAIL oe_wr_flagc got=%b exp=1", a_flagc); end
  endtask

  task automatic test_cs_high();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      slcs = 1'b1; sloe = 1'b1; slrd = 1'b0; slwr = 1'b0; pktend = 1'b0;
      tb_drv = 1'b1; tb_data = 32'h77;
      addr = (i == 0) ? 2'd0 : 2'd2;
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++; if ({a_words, a_pkts, a_err} !== 33'd0) begin n_fail++; $display("FAIL cs_high_counters got=%h/%h/%b exp=0", a_words, a_pkts, a_err); end
    n_checks++; if (a_flagc !== 1'b1) begin n_fail++; $display("FAIL cs_high_flagc got=%b exp=1", a_flagc); end
    drive_read();
    #1;
    n_checks++; if (fd_a !== 16'd1) begin n_fail++; $display("FAIL cs_high_no_advance got=%h exp=0001", fd_a); end
    @(negedge clk);
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (2) @(negedge clk);
    test_reset();
    test_download();
    test_wrap8();
    test_lfsr();
    test_upload_full();
    test_pktend();
    test_mid_reset();
    test_contention();
    test_cs_high();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_slfifo_vip.md
USB_SLFIFO_VIP -- requirements
Module: usb_slfifo_vip

Interface
REQ-001 Parameter DATA_W, default 16, bus width; legal values 8, 16 and 32.
REQ-002 Parameter DL_LEN, default 256, number of words the download endpoint supplies; legal range 1..65535.
REQ-003 Parameter UL_DEPTH, default 512, upload capture buffer depth in words; power of two.
REQ-004 Parameter DL_ADDR, default 2'd0, fifoaddr of the download (VIP-to-DUT) endpoint.
REQ-005 Parameter UL_ADDR, default 2'd2, fifoaddr of the upload (DUT-to-VIP) endpoint; must differ from DL_ADDR.
REQ-006 Parameter PAT_MODE, default 0; 0 selects incrementing data, 1 selects a DATA_W-bit Fibonacci LFSR.
REQ-007 Parameter PAT_SEED, default 1, first download word; an LFSR seed of 0 is forced to 1.
REQ-008 Parameter STARTUP_CYC, default 10, cycles after reset during which every flag reads "not ready".
REQ-009 Ports, clock and reset first:
- usb_clk  in  1  single clock; all sampling on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- usb_fifoaddr  in  2  endpoint select.
- usb_slcs  in  1  chip select, active low.
- usb_sloe  in  1  output enable, active low.
- usb_slrd  in  1  read strobe, active low.
- usb_slwr  in  1  write strobe, active low.
- usb_pktend  in  1  commit the current upload packet, active low.
- usb_fd  inout  DATA_W  bidirectional data bus.
- usb_flaga  out  1  download data available, high = available.
- usb_flagb  out  1  upload space available, high = not full.
- usb_flagc  out  1  upload buffer empty, high = empty.
- usb_download_finished  out  1  all DL_LEN words have been read.
- ul_word_cnt  out  16  total upload words accepted.
- ul_pkt_cnt  out  16  upload packets committed.
- ul_err  out  1  sticky protocol error.
- ul_rd_en  in  1  testbench pop from the upload buffer.
- ul_rd_data  out  DATA_W  head of the upload buffer.

Function
REQ-010 A start-up counter shall saturate at STARTUP_CYC; while below it, flaga=0, flagb=0 and flagc=1.
REQ-011 A download read shall be accepted on a clock edge when all of these hold: slcs=0, slrd=0, fifoaddr=DL_ADDR, and remaining words >0.
- Each accepted read advances the pattern once and decrements the remaining count.
REQ-012 usb_fd shall be driven only while slcs=0, sloe=0 and fifoaddr=DL_ADDR, and shall present the current pattern word combinationally; otherwise it is high-Z.
REQ-013 The first word driven after reset shall be PAT_SEED. Incrementing mode shall wrap modulo 2^DATA_W.
REQ-014 flaga shall equal (start-up done AND remaining >0). usb_download_finished shall be 1 exactly when remaining=0.
- Reads with remaining=0 shall be ignored and shall set ul_err.
REQ-015 An upload write shall be accepted on a clock edge when all of these hold: slcs=0, slwr=0, fifoaddr=UL_ADDR, and the buffer is not full.
- The accepted write pushes the usb_fd value and increments ul_word_cnt (saturating at 16'hFFFF).
REQ-016 A write while the buffer is full shall be dropped and shall set ul_err. flagb shall equal (start-up done AND not full).
REQ-017 pktend=0 with slcs=0 and fifoaddr=UL_ADDR shall increment ul_pkt_cnt once per asserted cycle.
- A pktend coincident with an accepted write shall commit that packet including the write.
REQ-018 Simultaneous slrd=0 and slwr=0 with slcs=0, and any strobe while slcs=0 and the bus is driven by both sides (sloe=0 and slwr=0), shall set ul_err; the write shall not be accepted.
REQ-019 ul_rd_data shall show the buffer head. An ul_rd_en pop and a bus push in the same cycle shall both complete, leaving occupancy unchanged. A pop when the buffer is empty is ignored.
REQ-020 Strobes with slcs=1 shall have no effect.

Reset
REQ-021 rst_n=0 shall asynchronously clear:
- the start-up counter, ul_word_cnt, ul_pkt_cnt, ul_err and buffer pointers;
- the remaining count, reloaded to DL_LEN;
- the pattern, reloaded to PAT_SEED.
Outputs during reset: flaga=0, flagb=0, flagc=1, finished=0, usb_fd high-Z.
REQ-022 Reset asserted mid-transfer shall discard partial data; the next download restarts from PAT_SEED.

Structure
REQ-023 The shared package/header usb_vip_pkg shall hold the PAT_MODE encodings, the default endpoint addresses and the LFSR tap table per DATA_W.
REQ-024 The pattern source shall be the sub-module usb_vip_pattern_gen (seed, advance, data out). The upload buffer shall be inline.

Verification
REQ-025 Reset, then read 256 words with DL_ADDR=0 and PAT_MODE=0 -> data 1..256; finished=1 and flaga=0 after the last edge; a 257th read sets ul_err.
REQ-026 DATA_W=8, PAT_SEED=8'hFE, 4 reads -> FE, FF, 00, 01.
REQ-027 UL_DEPTH=4, 5 writes of A1..A5 -> flagb=0 after the 4th, A5 dropped, ul_err=1, pops return A1..A4, then flagc=1.
REQ-028 Write 3 words with pktend on the 3rd edge -> ul_pkt_cnt=1 and ul_word_cnt=3.
REQ-029 Assert rst_n=0 after 100 reads -> flags take their reset values immediately; after release, the first read returns PAT_SEED.
REQ-030 slrd=0 and slwr=0 together with slcs=0 -> ul_err=1 and ul_word_cnt unchanged.
